ioctl_upload_port: RTL and testbench

Readback responder for the HPS ioctl upload channel: while `ioctl_upload` is high it serves `ioctl_rd` byte requests from a local synchronous RAM. Typical targets are work RAM and NVRAM for high-score save. It requests exclusive access from the CPU side first, stalls the HPS with `ioctl_wait` while a byte is being fetched, and releases the RAM when the upload ends. It sits beside the ROM download path in the top level and drives the shared `ioctl_din` bus.

---
 rtl/ioctl_upload_port_if.sv | 19 +
 rtl/ioctl_upload_port.sv | 196 +++++++++++++++++++
 tb/tb_ioctl_upload_port.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_upload_port_if.sv
// HPS ioctl upload channel as seen by a readback responder.
// master = HPS side, slave = responder.
interface ioctl_upload_port_if;
  logic        ioctl_upload;
  logic [26:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_addr, ioctl_rd,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_addr, ioctl_rd,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/ioctl_upload_port.sv
// Readback responder for the HPS ioctl upload channel: takes the RAM from the
// CPU via hold_req/hold_ack and serves ioctl_rd byte requests with ioctl_wait stalls.
module ioctl_upload_port #(
  parameter int unsigned AW   = 11,
  parameter logic [26:0] BASE = 27'h0,
  parameter int unsigned SIZE = 2048,
  parameter int unsigned LAT  = 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  ioctl_upload_port_if.slave  io,
  output logic                hold_req,
  input  logic                hold_ack,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_q,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_READY,
    S_FETCH,
    S_RELEASE
  } state_t;

  localparam logic [1:0] LAT_C = 2'(LAT);

  state_t        state_q, state_d;
  logic          upload_q, upload_d;
  logic          pend_q, pend_d;
  logic [26:0]   req_addr_q, req_addr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic          hold_q, hold_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic          mrd_q, mrd_d;
  logic          busy_q, busy_d;

  // A pending (early or abandoned) request takes precedence over the live bus address.
  logic [26:0] req_a;
  logic [26:0] req_off;
  logic        req_in;

  always_comb begin
    req_a   = pend_q ? req_addr_q : io.ioctl_addr;
    req_off = req_a - BASE;
    req_in  = (req_a >= BASE) && ({5'd0, req_off} < SIZE);
  end

  always_comb begin
    state_d    = state_q;
    upload_d   = io.ioctl_upload;
    pend_d     = pend_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    din_d      = din_q;
    wait_d     = wait_q;
    hold_d     = hold_q;
    maddr_d    = maddr_q;
    mrd_d      = mrd_q;

    case (state_q)
      S_IDLE: begin
        if (io.ioctl_upload && !upload_q) begin
          state_d = S_HOLD;
          hold_d  = 1'b1;
          wait_d  = 1'b1;
        end
      end

      S_HOLD: begin
        if (!io.ioctl_upload) begin
          state_d = S_IDLE;
          hold_d  = 1'b0;
          wait_d  = 1'b0;
          pend_d  = 1'b0;
        end else begin
          if (io.ioctl_rd && !pend_q) begin
            pend_d     = 1'b1;
            req_addr_d = io.ioctl_addr;
          end
          if (hold_ack) begin
            state_d = S_READY;
            wait_d  = pend_d;
          end
        end
      end

      S_READY: begin
        if (!io.ioctl_upload) begin
          state_d = S_RELEASE;
          hold_d  = 1'b0;
          wait_d  = 1'b0;
          pend_d  = 1'b0;
        end else if (!hold_ack) begin
          state_d = S_HOLD;
          wait_d  = 1'b1;
          if (io.ioctl_rd && !pend_q) begin
            pend_d     = 1'b1;
            req_addr_d = io.ioctl_addr;
          end
        end else if (pend_q || io.ioctl_rd) begin
          pend_d = 1'b0;
          if (req_in) begin
            state_d    = S_FETCH;
            req_addr_d = req_a;
            maddr_d    = req_off[AW-1:0];
            mrd_d      = 1'b1;
            wait_d     = 1'b1;
            cnt_d      = LAT_C;
          end else begin
            din_d  = 8'hFF;
            wait_d = 1'b0;
          end
        end
      end

      S_FETCH: begin
        // Losing the RAM abandons the fetch; req_addr_q is kept for the replay.
        if (!hold_ack) begin
          state_d = S_HOLD;
          mrd_d   = 1'b0;
          wait_d  = 1'b1;
          pend_d  = 1'b1;
        end else if (cnt_q == 2'd0) begin
          din_d  = mem_q;
          mrd_d  = 1'b0;
          wait_d = 1'b0;
          if (io.ioctl_upload) begin
            state_d = S_READY;
          end else begin
            state_d = S_RELEASE;
            hold_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      S_RELEASE: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
        wait_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
        wait_d  = 1'b0;
        mrd_d   = 1'b0;
        pend_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      upload_q   <= 1'b0;
      pend_q     <= 1'b0;
      req_addr_q <= '0;
      cnt_q      <= '0;
      din_q      <= 8'h00;
      wait_q     <= 1'b0;
      hold_q     <= 1'b0;
      maddr_q    <= '0;
      mrd_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      upload_q   <= upload_d;
      pend_q     <= pend_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      hold_q     <= hold_d;
      maddr_q    <= maddr_d;
      mrd_q      <= mrd_d;
      busy_q     <= busy_d;
    end
  end

  assign io.ioctl_din  = din_q;
  assign io.ioctl_wait = wait_q;
  assign hold_req      = hold_q;
  assign mem_addr      = maddr_q;
  assign mem_rd        = mrd_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ioctl_upload_port.sv
// Directed bench for ioctl_upload_port: three instances cover LAT=1/BASE=0,
// LAT=2 full dump, and BASE=0x100/SIZE=16 range handling.
module tb_ioctl_upload_port;

  logic clk;
  logic rst_n;

  logic [2:0]        up_v, rd_v, ack_v;
  logic [2:0][26:0]  addr_v;
  logic [2:0][7:0]   din_v, mq_v;
  logic [2:0]        wait_v, hreq_v, mrd_v, busy_v;
  logic [2:0][10:0]  maddr_v;

  int n_chk;
  int n_fail;

  // RAM image shared by all instances; RAM[5] = A7, RAM[0] = 5A, RAM[3] = 59, RAM[7] = 5D, RAM[15] = 55.
  function automatic logic [7:0] img(input logic [10:0] a);
    if (a == 11'd5) return 8'hA7;
    return a[7:0] ^ {5'd0, a[10:8]} ^ 8'h5A;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ioctl_upload_port_if bus ();
    logic [7:0] s1, s2, s3;

    assign bus.ioctl_upload = up_v[g];
    assign bus.ioctl_addr   = addr_v[g];
    assign bus.ioctl_rd     = rd_v[g];
    assign din_v[g]         = bus.ioctl_din;
    assign wait_v[g]        = bus.ioctl_wait;

    always @(posedge clk) begin
      s1 <= img(maddr_v[g]);
      s2 <= s1;
      s3 <= s2;
    end
    assign mq_v[g] = (g == 1) ? s2 : s1;

    ioctl_upload_port #(
      .AW   (11),
      .BASE ((g == 2) ? 27'h100 : 27'h0),
      .SIZE ((g == 2) ? 16 : 2048),
      .LAT  ((g == 1) ? 2 : 1)
    ) u_dut (
      .clk_sys  (clk),
      .reset_n  (rst_n),
      .io       (bus),
      .hold_req (hreq_v[g]),
      .hold_ack (ack_v[g]),
      .mem_addr (maddr_v[g]),
      .mem_rd   (mrd_v[g]),
      .mem_q    (mq_v[g]),
      .busy     (busy_v[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_req(input int u, input logic [26:0] a);
    addr_v[u] = a;
    rd_v[u]   = 1'b1;
    cyc(1);
    rd_v[u]   = 1'b0;
  endtask

  initial begin
    int k;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    up_v   = '0;
    rd_v   = '0;
    ack_v  = '0;
    addr_v = '0;
    cyc(2);

    check("rst_din",   32'(din_v[0]),   32'h00);
    check("rst_wait",  32'(wait_v[0]),  32'h0);
    check("rst_hreq",  32'(hreq_v[0]),  32'h0);
    check("rst_mrd",   32'(mrd_v[0]),   32'h0);
    check("rst_busy",  32'(busy_v[0]),  32'h0);
    check("rst_maddr", 32'(maddr_v[0]), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // Strobes while not uploading are ignored.
    rd_req(0, 27'd5);
    cyc(1);
    check("idle_mrd",  32'(mrd_v[0]),  32'h0);
    check("idle_hreq", 32'(hreq_v[0]), 32'h0);
    check("idle_din",  32'(din_v[0]),  32'h00);
    check("idle_busy", 32'(busy_v[0]), 32'h0);

    // Basic upload on instance 0 (LAT=1).
    up_v[0] = 1'b1;
    cyc(1);
    check("hold_req_up", 32'(hreq_v[0]), 32'h1);
    check("hold_wait",   32'(wait_v[0]), 32'h1);
    check("hold_busy",   32'(busy_v[0]), 32'h1);
    cyc(2);
    ack_v[0] = 1'b1;
    cyc(1);
    check("ready_wait", 32'(wait_v[0]), 32'h0);
    rd_req(0, 27'd5);
    check("rd5_wait0", 32'(wait_v[0]),  32'h1);
    check("rd5_mrd",   32'(mrd_v[0]),   32'h1);
    check("rd5_maddr", 32'(maddr_v[0]), 32'd5);
    cyc(1);
    check("rd5_wait1", 32'(wait_v[0]), 32'h1);
    cyc(1);
    check("rd5_wait2", 32'(wait_v[0]), 32'h0);
    check("rd5_din",   32'(din_v[0]),  32'hA7);
    check("rd5_mrd0",  32'(mrd_v[0]),  32'h0);

    up_v[0] = 1'b0;
    cyc(1);
    check("rel_hreq", 32'(hreq_v[0]), 32'h0);
    check("rel_busy", 32'(busy_v[0]), 32'h1);
    cyc(1);
    check("idle_busy2", 32'(busy_v[0]), 32'h0);
    ack_v[0] = 1'b0;
    cyc(1);

    // Early strobe while in HOLD.
    up_v[0] = 1'b1;
    cyc(1);
    rd_req(0, 27'd3);
    check("early_mrd",  32'(mrd_v[0]),  32'h0);
    check("early_wait", 32'(wait_v[0]), 32'h1);
    cyc(1);
    ack_v[0] = 1'b1;
    cyc(1);
    check("early_wait_rdy", 32'(wait_v[0]), 32'h1);
    cyc(1);
    check("early_mrd1",  32'(mrd_v[0]),   32'h1);
    check("early_maddr", 32'(maddr_v[0]), 32'd3);
    cyc(2);
    check("early_din",   32'(din_v[0]),  32'h59);
    check("early_wait0", 32'(wait_v[0]), 32'h0);

    // hold_ack dropped mid-fetch, then replayed.
    rd_req(0, 27'd7);
    ack_v[0] = 1'b0;
    cyc(1);
    check("abort_wait", 32'(wait_v[0]), 32'h1);
    check("abort_din",  32'(din_v[0]),  32'h59);
    check("abort_mrd",  32'(mrd_v[0]),  32'h0);
    cyc(2);
    check("abort_wait2", 32'(wait_v[0]), 32'h1);
    ack_v[0] = 1'b1;
    cyc(1);
    check("reack_wait", 32'(wait_v[0]), 32'h1);
    cyc(1);
    check("replay_mrd",   32'(mrd_v[0]),   32'h1);
    check("replay_maddr", 32'(maddr_v[0]), 32'd7);
    cyc(2);
    check("replay_din",   32'(din_v[0]),  32'h5D);
    check("replay_wait0", 32'(wait_v[0]), 32'h0);

    // Range handling on instance 2 (BASE=0x100, SIZE=16).
    up_v[2] = 1'b1;
    cyc(1);
    ack_v[2] = 1'b1;
    cyc(1);
    rd_req(2, 27'h0FF);
    check("oor_lo_din",  32'(din_v[2]),  32'hFF);
    check("oor_lo_wait", 32'(wait_v[2]), 32'h0);
    check("oor_lo_mrd",  32'(mrd_v[2]),  32'h0);
    rd_req(2, 27'h10F);
    check("top_wait",  32'(wait_v[2]),  32'h1);
    check("top_maddr", 32'(maddr_v[2]), 32'd15);
    cyc(2);
    check("top_din", 32'(din_v[2]), 32'h55);
    rd_req(2, 27'h110);
    check("oor_hi_din",  32'(din_v[2]),  32'hFF);
    check("oor_hi_wait", 32'(wait_v[2]), 32'h0);
    check("oor_hi_mrd",  32'(mrd_v[2]),  32'h0);
    rd_req(2, 27'h100);
    cyc(2);
    check("base_din", 32'(din_v[2]), 32'h5A);

    // Full sequential dump on instance 1 (LAT=2).
    up_v[1] = 1'b1;
    cyc(1);
    ack_v[1] = 1'b1;
    cyc(1);
    for (int a = 0; a < 2048; a++) begin
      rd_req(1, 27'(a));
      k = 0;
      while (wait_v[1] && k < 10) begin
        cyc(1);
        k++;
      end
      check("dump_lat",  32'(k),         32'd3);
      check("dump_data", 32'(din_v[1]), 32'(img(11'(a))));
    end

    // Asynchronous reset mid-fetch on instance 0.
    rd_req(0, 27'd5);
    check("pre_rst_mrd", 32'(mrd_v[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hreq",  32'(hreq_v[0]),  32'h0);
    check("arst_wait",  32'(wait_v[0]),  32'h0);
    check("arst_mrd",   32'(mrd_v[0]),   32'h0);
    check("arst_din",   32'(din_v[0]),   32'h00);
    check("arst_busy",  32'(busy_v[0]),  32'h0);
    check("arst_maddr", 32'(maddr_v[0]), 32'h0);
    up_v  = '0;
    ack_v = '0;
    #2;
    rst_n = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
